hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core; sole source of the write-enable and flush controls on the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazard classes:
  - load-use hazards, by stalling one cycle and injecting a bubble;
  - taken branches resolved in EX, by flushing the two wrong-path instructions;
  - data-memory wait states, by freezing the whole pipeline through a small FSM.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles, taken-branch flushes
// and data-memory wait freezes, plus a saturating stall counter and a sticky timeout flag.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rs,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_flush;
        logic exmem_wen;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};
    localparam ctrl_t CTRL_RESET  = '{pc_wen: 1'b0, ifid_wen: 1'b0, ifid_flush: 1'b1,
                                      idex_wen: 1'b0, idex_flush: 1'b1, exmem_wen: 1'b0};

    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               r_timeout_err;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_lu;
    ctrl_t              w_run_ctrl;
    ctrl_t              w_ctrl;

    // A load writing r0 never creates a dependency, so idex_rt==0 is excluded.
    assign w_lu = idex_memread && (idex_rt != 5'd0) &&
                  ((ifid_uses_rs && (idex_rt == ifid_rs)) ||
                   (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Branch beats load-use: the ID instruction is wrong-path and is flushed anyway.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_run_ctrl = '{default: 1'b1};
        w_run_ctrl.ifid_flush = 1'b0;
        w_run_ctrl.idex_flush = 1'b0;
        if (branch_taken) begin
            w_run_ctrl.ifid_flush = 1'b1;
            w_run_ctrl.idex_flush = 1'b1;
        end else if (w_lu) begin
            w_run_ctrl.pc_wen     = 1'b0;
            w_run_ctrl.ifid_wen   = 1'b0;
            w_run_ctrl.idex_flush = 1'b1;
        end
    end

    always_comb begin
        w_ctrl        = w_run_ctrl;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout_err;
        unique case (r_state)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_ctrl = CTRL_FREEZE;
                    if (r_wait_cnt != WAIT_MAX) begin
                        w_wait_nxt = r_wait_cnt + WAIT_ONE;
                    end
                    if (r_wait_cnt == TIMEOUT_VAL) begin
                        w_timeout_nxt = 1'b1;
                    end
                end else begin
                    // Release cycle: held branch/load-use are honoured, dmem_req is ignored.
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (rst) begin
            w_ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_timeout_err <= w_timeout_nxt;
            if (!w_ctrl.pc_wen && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign pc_wen      = w_ctrl.pc_wen;
    assign ifid_wen    = w_ctrl.ifid_wen;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_wen    = w_ctrl.idex_wen;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_wen   = w_ctrl.exmem_wen;
    assign stall_count = r_stall_cnt;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam logic [5:0] C_RUN    = 6'b110101; // {pc,ifid_wen,ifid_flush,idex_wen,idex_flush,exmem}
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_RESET  = 6'b001010;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_LU     = 6'b000111;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        bit          chk_state;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_uses_rs, ifid_uses_rt, idex_memread;
    logic        branch_taken, dmem_req, dmem_ready;
    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen;
    logic [15:0] stall_count;
    logic        timeout_err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_ctrl #(.CNT_W(16), .WAIT_W(8), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rs (ifid_uses_rs),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_wen       (pc_wen),
        .ifid_wen     (ifid_wen),
        .ifid_flush   (ifid_flush),
        .idex_wen     (idex_wen),
        .idex_flush   (idex_flush),
        .exmem_wen    (exmem_wen),
        .stall_count  (stall_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Load-use operand patterns: 0 no load, 1 rs hit, 2 rt hit, 3 rt==0, 4 hit but unused.
    task automatic set_lu(input int mode);
        idex_memread = (mode != 0);
        ifid_uses_rs = 1'b1;
        ifid_uses_rt = 1'b1;
        idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd2;
        case (mode)
            2: begin idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; end
            3: begin idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; end
            4: begin ifid_rt = 5'd5; ifid_uses_rs = 1'b0; ifid_uses_rt = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic apply(input string name, input logic r, input logic br, input int lu_mode,
                         input logic req, input logic rdy, input logic [5:0] ctrl,
                         input bit chk_state, input logic [15:0] cnt, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; branch_taken = br; dmem_req = req; dmem_ready = rdy;
        set_lu(lu_mode);
        e.name = name; e.ctrl = ctrl; e.chk_state = chk_state; e.cnt = cnt; e.to = to;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "/ctrl"},
                  32'({pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen}),
                  32'(e.ctrl));
            if (e.chk_state) begin
                check({e.name, "/stall_count"}, 32'(stall_count), 32'(e.cnt));
                check({e.name, "/timeout_err"}, 32'(timeout_err), 32'(e.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        set_lu(1);
        //     name           rst br lu req rdy ctrl      chk cnt  to
        apply("rst0",         1, 1, 1, 1, 0, C_RESET,  0, 0,  0);
        apply("rst1",         1, 1, 1, 1, 0, C_RESET,  1, 0,  0);
        apply("run_first",    0, 0, 0, 0, 0, C_RUN,    1, 0,  0);
        apply("lu_rs",        0, 0, 1, 0, 0, C_LU,     1, 0,  0);
        apply("after_lu",     0, 0, 0, 0, 0, C_RUN,    1, 1,  0);
        apply("lu_rt_zero",   0, 0, 3, 0, 0, C_RUN,    1, 1,  0);
        apply("lu_rt",        0, 0, 2, 0, 0, C_LU,     1, 1,  0);
        apply("lu_unused",    0, 0, 4, 0, 0, C_RUN,    1, 2,  0);
        apply("br_over_lu",   0, 1, 1, 0, 0, C_BRANCH, 1, 2,  0);
        apply("after_br",     0, 0, 0, 0, 0, C_RUN,    1, 2,  0);
        apply("zero_wait",    0, 0, 0, 1, 1, C_RUN,    1, 2,  0);
        apply("miss",         0, 0, 0, 1, 0, C_FREEZE, 1, 2,  0);
        apply("wait1",        0, 0, 0, 1, 0, C_FREEZE, 1, 3,  0);
        apply("wait2",        0, 0, 0, 1, 0, C_FREEZE, 1, 4,  0);
        apply("release",      0, 0, 0, 1, 1, C_RUN,    1, 5,  0);
        apply("br_miss",      0, 1, 0, 1, 0, C_FREEZE, 1, 5,  0);
        apply("br_wait",      0, 1, 0, 1, 0, C_FREEZE, 1, 6,  0);
        apply("br_release",   0, 1, 0, 1, 1, C_BRANCH, 1, 7,  0);
        apply("after_brrel",  0, 0, 0, 0, 0, C_RUN,    1, 7,  0);
        apply("lu_miss",      0, 0, 1, 1, 0, C_FREEZE, 1, 7,  0);
        apply("lu_release",   0, 0, 1, 1, 1, C_LU,     1, 8,  0);
        apply("after_lurel",  0, 0, 0, 0, 0, C_RUN,    1, 9,  0);
        apply("b2b_miss_a",   0, 0, 0, 1, 0, C_FREEZE, 1, 9,  0);
        apply("b2b_rel_a",    0, 0, 0, 1, 1, C_RUN,    1, 10, 0);
        apply("b2b_miss_b",   0, 0, 0, 1, 0, C_FREEZE, 1, 10, 0);
        apply("b2b_rel_b",    0, 0, 0, 0, 1, C_RUN,    1, 11, 0);
        apply("to_miss",      0, 0, 0, 1, 0, C_FREEZE, 1, 11, 0);
        apply("to_w1",        0, 0, 0, 1, 0, C_FREEZE, 1, 12, 0);
        apply("to_w2",        0, 0, 0, 1, 0, C_FREEZE, 1, 13, 0);
        apply("to_w3",        0, 0, 0, 1, 0, C_FREEZE, 1, 14, 0);
        apply("to_w4",        0, 0, 0, 1, 0, C_FREEZE, 1, 15, 0);
        apply("to_w5",        0, 0, 0, 1, 0, C_FREEZE, 1, 16, 1);
        apply("to_release",   0, 0, 0, 1, 1, C_RUN,    1, 17, 1);
        apply("to_sticky",    0, 0, 0, 0, 0, C_RUN,    1, 17, 1);
        apply("rw_miss",      0, 0, 0, 1, 0, C_FREEZE, 1, 17, 1);
        apply("rw_reset",     1, 0, 0, 1, 0, C_RESET,  1, 18, 1);
        apply("rw_run",       0, 0, 0, 0, 0, C_RUN,    1, 0,  0);
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
